// File: rtl/estagio_busca.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | estagio_busca: instruction fetch with req/ack memory, IF/ID register and |
// | one-entry skid. Optional BUSCA_DESALINHADO_EN halts on misaligned target.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module estagio_busca #(
  parameter int             TAM      = 32,
  parameter logic [TAM-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           parada,
  input  logic           desvio,
  input  logic [TAM-1:0] alvo_desvio,
  output logic           mem_req,
  output logic [TAM-1:0] mem_endereco,
  input  logic           mem_ack,
  input  logic [TAM-1:0] mem_dado,
  output logic [TAM-1:0] pc_id,
  output logic [TAM-1:0] pc4_id,
  output logic [TAM-1:0] instrucao_id,
  output logic           valido_id
`ifdef BUSCA_DESALINHADO_EN
  ,
  output logic           erro_alinhamento
`endif
);

  localparam logic [TAM-1:0] c_PASSO = TAM'(4);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESPERA   = 3'd1,
    RETIDO   = 3'd2,
    DESCARTA = 3'd3,
    PARADO   = 3'd4
  } estado_t;

  estado_t        r_estado, w_prox_estado;
  logic [TAM-1:0] r_pc, w_prox_pc;
  logic [TAM-1:0] r_skid_pc, r_skid_dado;
  logic [TAM-1:0] r_pc_id, r_pc4_id, r_instrucao_id;
  logic           r_valido_id;

  logic           w_aceita;
  logic           w_carrega_id, w_limpa_id, w_carrega_skid;
  logic [TAM-1:0] w_fonte_pc, w_fonte_dado;
  logic [TAM-1:0] w_alvo;

  assign w_aceita = !parada || !r_valido_id;
`ifdef BUSCA_DESALINHADO_EN
  assign w_alvo = {alvo_desvio[TAM-1:2], 2'b00};
`else
  assign w_alvo = {alvo_desvio[TAM-1:2], alvo_desvio[1:0] & 2'b00};
`endif

  always_comb begin
    w_prox_estado  = r_estado;
    w_prox_pc      = r_pc;
    w_carrega_id   = 1'b0;
    w_limpa_id     = 1'b0;
    w_carrega_skid = 1'b0;
    w_fonte_pc     = r_pc;
    w_fonte_dado   = mem_dado;
    if (r_estado == PARADO) begin
      w_limpa_id = 1'b1;
    end else if (desvio) begin
      // Redirect beats stall and ack; an in-flight request without ack must be drained.
      w_prox_pc  = w_alvo;
      w_limpa_id = 1'b1;
      case (r_estado)
        ESPERA:   w_prox_estado = mem_ack ? ESPERA : DESCARTA;
        DESCARTA: w_prox_estado = DESCARTA;
        default:  w_prox_estado = ESPERA;
      endcase
`ifdef BUSCA_DESALINHADO_EN
      if (alvo_desvio[1:0] != 2'b00) w_prox_estado = PARADO;
`endif
    end else begin
      case (r_estado)
        OCIOSO: begin
          w_prox_estado = ESPERA;
          w_limpa_id    = w_aceita;
        end
        ESPERA: begin
          if (mem_ack) begin
            w_prox_pc = r_pc + c_PASSO;
            if (w_aceita) begin
              w_carrega_id = 1'b1;
            end else begin
              w_carrega_skid = 1'b1;
              w_prox_estado  = RETIDO;
            end
          end else begin
            w_limpa_id = w_aceita;
          end
        end
        RETIDO: begin
          if (!parada) begin
            w_carrega_id  = 1'b1;
            w_fonte_pc    = r_skid_pc;
            w_fonte_dado  = r_skid_dado;
            w_prox_estado = ESPERA;
          end
        end
        DESCARTA: begin
          if (mem_ack) w_prox_estado = ESPERA;
          w_limpa_id = w_aceita;
        end
        default: w_prox_estado = r_estado;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_pc           <= RESET_PC;
      r_skid_pc      <= '0;
      r_skid_dado    <= '0;
      r_pc_id        <= '0;
      r_pc4_id       <= '0;
      r_instrucao_id <= '0;
      r_valido_id    <= 1'b0;
    end else begin
      r_estado <= w_prox_estado;
      r_pc     <= w_prox_pc;
      if (w_carrega_skid) begin
        r_skid_pc   <= r_pc;
        r_skid_dado <= mem_dado;
      end
      if (w_carrega_id) begin
        r_pc_id        <= w_fonte_pc;
        r_pc4_id       <= w_fonte_pc + c_PASSO;
        r_instrucao_id <= w_fonte_dado;
        r_valido_id    <= 1'b1;
      end else if (w_limpa_id) begin
        r_valido_id <= 1'b0;
      end
    end
  end

`ifdef BUSCA_DESALINHADO_EN
  logic r_erro;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_erro <= 1'b0;
    end else if (r_estado != PARADO && desvio && alvo_desvio[1:0] != 2'b00) begin
      r_erro <= 1'b1;
    end
  end

  assign erro_alinhamento = r_erro;
`endif

  assign mem_req      = (r_estado == ESPERA);
  assign mem_endereco = r_pc;
  assign pc_id        = r_pc_id;
  assign pc4_id       = r_pc4_id;
  assign instrucao_id = r_instrucao_id;
  assign valido_id    = r_valido_id;

endmodule
`default_nettype wire

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
Instruction-fetch stage that feeds the decode stage. It owns the program counter and issues word requests to instruction memory over a req/ack handshake, so memory latency can vary (zero-wait ROM or a UART-loaded RAM). It holds the IF/ID pipeline register, with a valid bit and a one-entry skid buffer. It also honours stall ("parada") and branch/jump redirect ("desvio") requests coming back from decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
TAM, 32, data and address width.

Ports:
clock  input  1  Rising-edge clock for all state.
reset  input  1  Asynchronous, active-high reset.
parada  input  1  Decode stall; hold IF/ID contents.
desvio  input  1  Redirect taken, resolved in decode.
alvo_desvio  input  TAM  Redirect target address.
mem_req  output  1  Instruction memory request.
mem_endereco  output  TAM  Word address of the request.
mem_ack  input  1  Memory response valid; may be asserted in the same cycle as mem_req.
mem_dado  input  TAM  Instruction word; valid when mem_ack=1.
pc_id  output  TAM  Address of the instruction in IF/ID.
pc4_id  output  TAM  pc_id+4.
instrucao_id  output  TAM  Instruction word in IF/ID.
valido_id  output  1  IF/ID holds a live instruction.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC; state=OCIOSO.
  - mem_req=0, mem_endereco=RESET_PC.
  - valido_id=0, pc_id=0, pc4_id=0, instrucao_id=32'h0 (NOP).
  - Skid buffer empty.
- Reset during an outstanding request abandons that request; memory must tolerate a dropped request.
- States:
  - OCIOSO: first cycle after reset release; mem_req=0. Always goes to ESPERA.
  - ESPERA: mem_req=1, mem_endereco=pc. Address is held stable until mem_ack.
  - RETIDO: skid buffer full; mem_req=0.
  - DESCARTA: redirect hit while a request was in flight; mem_req=0; waiting for the stale ack.
- Acceptance: IF/ID can accept when parada=0 or valido_id=0. A bubble never blocks.
- ESPERA, mem_ack=1, IF/ID accepts:
  - Next edge: instrucao_id=mem_dado, pc_id=pc, pc4_id=pc+4, valido_id=1.
  - pc<=pc+4; stay in ESPERA, requesting pc+4 the next cycle.
  - Throughput is 1 instruction/cycle with a zero-wait memory.
- ESPERA, mem_ack=1, IF/ID blocked: capture {pc, mem_dado} in the skid buffer; pc<=pc+4; go to RETIDO.
- RETIDO, first cycle with parada=0: skid moves into IF/ID (valido_id=1); skid empties; go to ESPERA.
- IF/ID hold: when parada=1 and valido_id=1, pc_id, pc4_id and instrucao_id are unchanged.
- IF/ID drain: when the IF/ID can accept and no new word arrives that cycle, valido_id<=0 and data fields hold.
- Redirect (desvio=1) has priority over parada and mem_ack:
  - Next edge: pc<={alvo_desvio[TAM-1:2],2'b00}; valido_id<=0; skid cleared.
  - From ESPERA without mem_ack: go to DESCARTA.
  - From ESPERA with mem_ack: the word is dropped; stay in ESPERA and request the target next cycle.
  - From RETIDO or OCIOSO: go to ESPERA.
- DESCARTA, mem_ack=1: data discarded; go to ESPERA at the new pc.
- DESCARTA, another desvio: pc is updated to the newest target; stay in DESCARTA.
- Arithmetic: PC math is modulo 2^TAM; 32'hFFFF_FFFC+4 wraps to 0. pc4_id also wraps.
- No combinational path from parada, desvio or alvo_desvio to mem_req or mem_endereco. Only registered state drives them.

Optional Feature:
- Macro BUSCA_DESALINHADO_EN.
- When defined:
  - Adds output erro_alinhamento (1 bit, reset 0).
  - A redirect with alvo_desvio[1:0]!=0 sets erro_alinhamento=1 on the next edge; it is sticky until reset.
  - The FSM goes to a halted state with mem_req=0, valido_id=0.
  - Only reset exits the halted state.
- When undefined: alvo_desvio[1:0] is silently forced to 00 and no extra port exists.

Test Plan:
- Zero-wait memory (mem_ack tied to mem_req, mem_dado=address), release reset: valido_id rises 2 cycles after release; pc_id runs 0,4,8,C on consecutive cycles; pc4_id=pc_id+4.
- 3-cycle-latency memory: mem_endereco held at 0x4 for 3 cycles with mem_req=1; IF/ID updates once per ack; valido_id=0 during gaps.
- parada=1 for 4 cycles with an ack landing during the stall: IF/ID holds 0x8; skid captures 0xC; mem_req=0 in RETIDO. parada=0 yields 0xC the next edge, then 0x10; no word lost or duplicated.
- desvio=1, alvo=0x100 while a 3-cycle request to 0x10 is in flight: valido_id=0 next edge; the stale ack is discarded; next request address is 0x100; pc_id=0x100 appears. With desvio and parada asserted together, the flush still happens.
- Wrap: desvio to 0xFFFFFFFC: pc4_id=0; next fetch address is 0x0. Async reset mid-ESPERA: all outputs at reset values immediately, without waiting for a clock edge.
- With BUSCA_DESALINHADO_EN, desvio to 0x102: erro_alinhamento=1; mem_req stays 0 for 10 cycles. Without the macro: fetch proceeds at 0x100.
